booth_multiplier: RTL and testbench

Sequential 32×32 signed multiplier using radix-4 (modified) Booth recoding, the multiply-side counterpart of the non-restoring divider step in the multdiv unit. Accepts a start pulse with two operands, retires two multiplier bits per clock over 16 iterations, and returns the low 32 bits of the product with an overflow flag and a one-cycle ready strobe. Sits beside the divider inside the multdiv wrapper that feeds the processor's execute stage.

---
 rtl/booth_multiplier_pkg.sv | 29 ++
 rtl/booth_multiplier_if.sv | 20 ++
 rtl/booth_multiplier_recoder.sv | 19 +
 rtl/booth_multiplier.sv | 100 ++++++++++
 tb/tb_booth_multiplier.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/booth_multiplier_pkg.sv
// Shared multdiv definitions: Booth recoding ops, iteration count and FSM states.
package booth_multiplier_pkg;

    localparam int unsigned ITER_COUNT = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ACC_W      = DATA_W + 2;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_PM   = 3'd1,
        OP_P2M  = 3'd2,
        OP_NM   = 3'd3,
        OP_N2M  = 3'd4
    } booth_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // The 64-bit product fits in signed 32 bits only when its top 33 bits agree.
    function automatic logic mult_overflow(input logic [ACC_W-1:0] acc, input logic q_msb);
        logic [ACC_W:0] hi;
        hi = {acc, q_msb};
        return !((&hi) || (~|hi));
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle between the multdiv wrapper and the Booth multiplier.
interface booth_multiplier_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_multiplier_recoder.sv
// Radix-4 Booth recoder: maps the {Q[1:0], q_m1} window to an add/subtract op.
module booth_recoder
    import booth_multiplier_pkg::*;
(
    input  logic [2:0] win_i,
    output booth_op_e  op_o
);
    always_comb begin
        op_o = OP_ZERO;
        unique case (win_i)
            3'b000, 3'b111: op_o = OP_ZERO;
            3'b001, 3'b010: op_o = OP_PM;
            3'b011:         op_o = OP_P2M;
            3'b100:         op_o = OP_N2M;
            3'b101, 3'b110: op_o = OP_NM;
            default:        op_o = OP_ZERO;
        endcase
    end
endmodule

// File: rtl/booth_multiplier.sv
// Sequential 32x32 signed radix-4 Booth multiplier: 16 steps, 17 cycles start-to-strobe.
// Starts are ignored while iterating; a start in the DONE cycle reloads with no bubble.
module booth_multiplier
    import booth_multiplier_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    booth_multiplier_if.slave    bus
);
    mult_state_e       state_q;
    logic [ACC_W-1:0]  a_q, m_q;
    logic [DATA_W-1:0] q_q;
    logic              qm1_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] result_q;
    logic              exc_q, rdy_q, busy_q;

    booth_op_e         op;
    logic [ACC_W-1:0]  addend, sum;
    logic [ACC_W-1:0]  a_d;
    logic [DATA_W-1:0] q_d;
    logic              qm1_d;

    booth_recoder u_recoder (
        .win_i ({q_q[1:0], qm1_q}),
        .op_o  (op)
    );

    always_comb begin
        addend = '0;
        unique case (op)
            OP_PM:   addend = m_q;
            OP_P2M:  addend = m_q << 1;
            OP_NM:   addend = -m_q;
            OP_N2M:  addend = -(m_q << 1);
            default: addend = '0;
        endcase
        sum   = a_q + addend;
        // Arithmetic shift right by two of {A, Q, q_m1}
        a_d   = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        q_d   = {sum[1:0], q_q[DATA_W-1:2]};
        qm1_d = q_q[1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    rdy_q <= 1'b0;
                    if (bus.ctrl_MULT) begin
                        state_q <= ST_RUN;
                        a_q     <= '0;
                        q_q     <= bus.data_operandB;
                        qm1_q   <= 1'b0;
                        m_q     <= {{2{bus.data_operandA[DATA_W-1]}}, bus.data_operandA};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER_COUNT - 1)) begin
                        state_q  <= ST_DONE;
                        result_q <= q_d;
                        exc_q    <= mult_overflow(a_d, q_d[DATA_W-1]);
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random checks of booth_multiplier against a plain-arithmetic product model.
module tb_booth_multiplier;
    logic clock = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic do_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[31:0];
    endfunction

    function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p != {{32{p[31]}}, p[31:0]};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        do_edge();
        bus.ctrl_MULT     = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (bus.data_resultRDY !== 1'b1 && n < 40) begin
            do_edge();
            n++;
        end
    endtask

    task automatic count_strobes(input int cycles, output int s);
        s = 0;
        for (int i = 0; i < cycles; i++) begin
            do_edge();
            if (bus.data_resultRDY === 1'b1) s++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        start_op(a, b);
        wait_rdy(n);
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_result"}, 64'(bus.data_result), 64'(model_result(a, b)));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(model_exc(a, b)));
        do_edge();
        check({tag, "_strobe_len"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, "_hold"}, 64'(bus.data_result), 64'(model_result(a, b)));
    endtask

    initial begin
        int n, s;
        logic [31:0] ra, rb;

        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) do_edge();
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset_n = 1'b1;
        do_edge();

        run_and_check("m3x4", 32'd3, 32'd4);
        check("m3x4_const", 64'(bus.data_result), 64'h0000_000C);
        run_and_check("m_7x6", 32'hFFFF_FFF9, 32'd6);
        check("m_7x6_const", 64'(bus.data_result), 64'hFFFF_FFD6);
        run_and_check("m6x_7", 32'd6, 32'hFFFF_FFF9);
        check("m6x_7_const", 64'(bus.data_result), 64'hFFFF_FFD6);
        run_and_check("max_x2", 32'h7FFF_FFFF, 32'd2);
        check("max_x2_exc", 64'(bus.data_exception), 64'd1);
        run_and_check("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        check("min_x_m1_const", 64'(bus.data_result), 64'h8000_0000);
        check("min_x_m1_exc", 64'(bus.data_exception), 64'd1);
        run_and_check("min_x1", 32'h8000_0000, 32'd1);
        check("min_x1_exc", 64'(bus.data_exception), 64'd0);

        // Start pulse during RUN must be ignored
        start_op(32'd5, 32'd5);
        repeat (5) do_edge();
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        do_edge();
        bus.ctrl_MULT     = 1'b0;
        wait_rdy(n);
        check("ign_latency", 64'(n + 6), 64'd16);
        check("ign_result", 64'(bus.data_result), 64'd25);
        count_strobes(30, s);
        check("ign_no_second", 64'(s), 64'd0);

        // Back-to-back: new start accepted in the DONE cycle
        start_op(32'd5, 32'd5);
        wait_rdy(n);
        check("b2b_first", 64'(bus.data_result), 64'd25);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'hFFFF_FFFF;
        bus.data_operandB = 32'hFFFF_FFFF;
        do_edge();
        bus.ctrl_MULT     = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_rdy_low", 64'(bus.data_resultRDY), 64'd0);
        wait_rdy(n);
        check("b2b_latency", 64'(n + 1), 64'd17);
        check("b2b_result", 64'(bus.data_result), 64'd1);
        check("b2b_exc", 64'(bus.data_exception), 64'd0);
        do_edge();

        // Reset in the middle of an operation
        start_op(32'd7, 32'd11);
        repeat (7) do_edge();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_result", 64'(bus.data_result), 64'd0);
        check("mid_rst_exc", 64'(bus.data_exception), 64'd0);
        check("mid_rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        do_edge();
        reset_n = 1'b1;
        count_strobes(25, s);
        check("mid_rst_no_strobe", 64'(s), 64'd0);
        run_and_check("after_rst", 32'd123, 32'hFFFF_FE38);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                ra = 32'($urandom_range(0, 65535)) - 32'd32768;
                rb = 32'($urandom_range(0, 65535)) - 32'd32768;
            end
            run_and_check($sformatf("rnd%0d", i), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
